// File: rtl/eic_arbiter_pkg.sv
// Shared definitions for the external interrupt controller arbiter.
//   TRUE / FALSE   : single-bit logic constants
//   eic_state_e    : handshake FSM state encoding
//   eic_cnt_width  : counter width for the setup / recovery countdowns
package eic_arbiter_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSetup   = 2'd1,
    StReq     = 2'd2,
    StRecover = 2'd3
  } eic_state_e;

  // The counter is loaded with (cycles - 1), so $clog2 of the larger
  // cycle count is always wide enough.
  function automatic int unsigned eic_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/eic_priority_encoder.sv
// Fixed-priority encoder: lowest set index wins.
//   i_eligible : candidate vector
//   o_index    : index of the lowest set bit (0 when none)
//   o_valid    : at least one bit set
module eic_priority_encoder
  import eic_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ID_WIDTH = 1
) (
  input  logic [NUM_SRC-1:0]  i_eligible,
  output logic [ID_WIDTH-1:0] o_index,
  output logic                o_valid
);

  // Scan from the top down so the lowest set index is the last writer.
  always_comb begin
    o_index = '0;
    o_valid = FALSE;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (i_eligible[i]) begin
        o_index = ID_WIDTH'(i);
        o_valid = TRUE;
      end
    end
  end

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, flops clear to 0
//   i_d     : asynchronous input
//   o_q     : synchronized output
module synchronizer (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/eic_arbiter.sv
// External interrupt controller arbiter stage.
// Latches rising edges of the sources as pending bits, picks the lowest
// unmasked pending index and offers it to the core with a level request and
// toggle acknowledge. The ID is held stable SETUP_CYCLES before the request
// rises, and the request stays low at least LOW_CYCLES after an acknowledge.
// Constraints: 2**ID_WIDTH >= NUM_SRC, SETUP_CYCLES >= 2, LOW_CYCLES >= 3.
//   Sys_Clock   : clock
//   Sys_Reset   : asynchronous active-low reset
//   Src_IntReq  : interrupt sources, rising edge raises an event
//   Src_IntMask : 1 = excluded from arbitration (still latched as pending)
//   EIC_IntAck  : toggle acknowledge from the core domain (asynchronous)
//   EIC_IntReq  : request level to the core (flop output)
//   EIC_IntId   : requested interrupt ID (flop output)
//   EIC_Pending : pending-bit status
module eic_arbiter
  import eic_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned LOW_CYCLES   = 3
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  input  logic [NUM_SRC-1:0]  Src_IntReq,
  input  logic [NUM_SRC-1:0]  Src_IntMask,
  input  logic                EIC_IntAck,
  output logic                EIC_IntReq,
  output logic [ID_WIDTH-1:0] EIC_IntId,
  output logic [NUM_SRC-1:0]  EIC_Pending
);

  localparam int unsigned CNT_W = eic_cnt_width(SETUP_CYCLES, LOW_CYCLES);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD   = CNT_W'(LOW_CYCLES - 1);

  eic_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_SRC-1:0]  r_src_last;
  logic [NUM_SRC-1:0]  r_pending;
  logic                r_ack_sync_last;
  logic                r_int_req;
  logic [ID_WIDTH-1:0] r_int_id;

  logic [NUM_SRC-1:0]  w_rise;
  logic [NUM_SRC-1:0]  w_eligible;
  logic [NUM_SRC-1:0]  w_clr;
  logic [ID_WIDTH-1:0] w_sel_id;
  logic                w_sel_valid;
  logic                w_ack_sync;
  logic                w_ack_evt;

  synchronizer u_ack_sync (
    .i_clk   (Sys_Clock),
    .i_rst_n (Sys_Reset),
    .i_d     (EIC_IntAck),
    .o_q     (w_ack_sync)
  );

  eic_priority_encoder #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_prio (
    .i_eligible (w_eligible),
    .o_index    (w_sel_id),
    .o_valid    (w_sel_valid)
  );

  assign w_rise     = Src_IntReq & ~r_src_last;
  assign w_eligible = r_pending & ~Src_IntMask;
  assign w_ack_evt  = w_ack_sync ^ r_ack_sync_last;

  // Only an acknowledge taken in StReq retires the committed ID.
  always_comb begin
    w_clr = '0;
    if (r_state == StReq && w_ack_evt) begin
      w_clr[r_int_id] = TRUE;
    end
  end

  // Set has priority over clear so an edge coincident with the ack survives.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_src_last <= '0;
      r_pending  <= '0;
    end else begin
      r_src_last <= Src_IntReq;
      r_pending  <= (r_pending & ~w_clr) | w_rise;
    end
  end

  // Handshake FSM. The ID is latched on leaving StIdle and frozen until the
  // next StIdle, so later mask changes or arrivals cannot disturb it.
  always_ff @(posedge Sys_Clock or negedge Sys_Reset) begin
    if (!Sys_Reset) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_int_req       <= FALSE;
      r_int_id        <= '0;
      r_ack_sync_last <= FALSE;
    end else begin
      // Acks seen outside StReq are absorbed here and otherwise ignored.
      r_ack_sync_last <= w_ack_sync;
      unique case (r_state)
        StIdle: begin
          if (w_sel_valid) begin
            r_int_id <= w_sel_id;
            r_cnt    <= SETUP_LOAD;
            r_state  <= StSetup;
          end
        end
        StSetup: begin
          if (r_cnt == '0) begin
            r_int_req <= TRUE;
            r_state   <= StReq;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        StReq: begin
          if (w_ack_evt) begin
            r_int_req <= FALSE;
            r_cnt     <= LOW_LOAD;
            r_state   <= StRecover;
          end
        end
        StRecover: begin
          if (r_cnt == '0) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign EIC_IntReq  = r_int_req;
  assign EIC_IntId   = r_int_id;
  assign EIC_Pending = r_pending;

endmodule

// File: tb/tb_eic_arbiter.sv
// Directed bench for eic_arbiter (NUM_SRC=2, ID_WIDTH=1, SETUP=2, LOW=3).
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_eic_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] src;
  logic [1:0] mask;
  logic       ack;
  logic       req;
  logic [0:0] id;
  logic [1:0] pend;

  int n_cmp;
  int n_err;

  eic_arbiter #(
    .NUM_SRC      (2),
    .ID_WIDTH     (1),
    .SETUP_CYCLES (2),
    .LOW_CYCLES   (3)
  ) dut (
    .Sys_Clock   (clk),
    .Sys_Reset   (rst_n),
    .Src_IntReq  (src),
    .Src_IntMask (mask),
    .EIC_IntAck  (ack),
    .EIC_IntReq  (req),
    .EIC_IntId   (id),
    .EIC_Pending (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse; returns on the falling edge after the pending bit latches.
  task automatic pulse(input logic [1:0] v);
    src = v;
    @(negedge clk);
    src = 2'b00;
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, req}, 32'd1);
  endtask

  // Toggle ack: the request must drop exactly three edges later.
  task automatic ack_fall(input string tag);
    ack = ~ack;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_hold"}, {31'd0, req}, 32'd1);
    @(negedge clk);
    chk({tag, "_fall"}, {31'd0, req}, 32'd0);
  endtask

  initial begin
    int low_cnt;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    src   = 2'b00;
    mask  = 2'b00;
    ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_id", {31'd0, id}, 32'd0);
    chk("rst_pend", {30'd0, pend}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single event with exact setup latency
    pulse(2'b10);
    chk("single_pend", {30'd0, pend}, 32'd2);
    @(negedge clk);
    chk("single_id", {31'd0, id}, 32'd1);
    chk("single_setup0", {31'd0, req}, 32'd0);
    @(negedge clk);
    chk("single_setup1", {31'd0, req}, 32'd0);
    @(negedge clk);
    chk("single_rise", {31'd0, req}, 32'd1);
    ack_fall("single");
    chk("single_clr", {30'd0, pend}, 32'd0);
    repeat (6) @(negedge clk);

    // Priority: both at once, 0 first
    pulse(2'b11);
    chk("prio_pend11", {30'd0, pend}, 32'd3);
    wait_rise("prio_rise0");
    chk("prio_id0", {31'd0, id}, 32'd0);
    ack_fall("prio0");
    chk("prio_pend10", {30'd0, pend}, 32'd2);
    wait_rise("prio_rise1");
    chk("prio_id1", {31'd0, id}, 32'd1);
    ack_fall("prio1");
    chk("prio_pend00", {30'd0, pend}, 32'd0);
    repeat (6) @(negedge clk);

    // Masking
    mask = 2'b01;
    pulse(2'b11);
    wait_rise("mask_rise1");
    chk("mask_id1", {31'd0, id}, 32'd1);
    ack_fall("mask1");
    chk("mask_pend01", {30'd0, pend}, 32'd1);
    repeat (8) @(negedge clk);
    chk("allmask_req", {31'd0, req}, 32'd0);
    chk("allmask_pend", {30'd0, pend}, 32'd1);
    mask = 2'b00;
    wait_rise("mask_rise0");
    chk("mask_id0", {31'd0, id}, 32'd0);
    ack_fall("mask0");
    chk("mask_pend00", {30'd0, pend}, 32'd0);
    repeat (6) @(negedge clk);

    // Set/clear collision on source 0
    pulse(2'b01);
    wait_rise("coll_rise");
    ack = ~ack;
    @(negedge clk);
    @(negedge clk);
    src = 2'b01;
    @(negedge clk);
    src = 2'b00;
    chk("coll_fall", {31'd0, req}, 32'd0);
    chk("coll_pend", {30'd0, pend}, 32'd1);
    low_cnt = 0;
    while (req !== 1'b1 && low_cnt < 20) begin
      low_cnt++;
      @(negedge clk);
    end
    chk("coll_low_cycles", low_cnt, 32'd6);
    chk("coll_id", {31'd0, id}, 32'd0);
    ack_fall("coll2");
    chk("coll_pend_clr", {30'd0, pend}, 32'd0);
    repeat (6) @(negedge clk);

    // Spurious ack in idle
    ack = ~ack;
    repeat (6) @(negedge clk);
    chk("spur_req", {31'd0, req}, 32'd0);
    chk("spur_pend", {30'd0, pend}, 32'd0);
    pulse(2'b10);
    wait_rise("spur_rise");
    chk("spur_id", {31'd0, id}, 32'd1);
    repeat (6) @(negedge clk);
    chk("spur_still_req", {31'd0, req}, 32'd1);
    ack_fall("spur");
    repeat (6) @(negedge clk);

    // Reset mid-request: asynchronous abort
    pulse(2'b11);
    wait_rise("rstmid_rise");
    chk("rstmid_pend_before", {30'd0, pend}, 32'd3);
    rst_n = 1'b0;
    ack   = 1'b0;
    #1;
    chk("rstmid_req", {31'd0, req}, 32'd0);
    chk("rstmid_pend", {30'd0, pend}, 32'd0);
    chk("rstmid_id", {31'd0, id}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rstmid_after_req", {31'd0, req}, 32'd0);
    chk("rstmid_after_pend", {30'd0, pend}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eic_arbiter.md
Name: eic_arbiter

Overview:
External interrupt controller stage that sits directly upstream of the core interrupt unit. It collects edge-triggered interrupt sources, latches them as pending and selects the highest-priority unmasked one. It then presents that ID to the core over the two-wire request/toggle-acknowledge handshake: EIC_IntReq/EIC_IntId out, EIC_IntAck in.
The core side samples EIC_IntReq and EIC_IntId through independent two-flop synchronizers and captures the ID on the synchronized rising edge of the request. This block therefore guarantees ID setup ahead of the request and a minimum low time after it.

Parameters:
NUM_SRC, 2, number of interrupt sources; index 0 has the highest priority.
ID_WIDTH, 1, width of EIC_IntId; must satisfy 2**ID_WIDTH >= NUM_SRC.
SETUP_CYCLES, 2, cycles EIC_IntId is held stable before EIC_IntReq rises; must be >= 2.
LOW_CYCLES, 3, minimum cycles EIC_IntReq stays low after an acknowledge; must be >= 3.

Ports:
Sys_Clock  input  1  block clock; single clock domain.
Sys_Reset  input  1  asynchronous, active-low reset.
Src_IntReq  input  NUM_SRC  interrupt sources, synchronous to Sys_Clock; a rising edge raises an event.
Src_IntMask  input  NUM_SRC  1 = source excluded from arbitration; its pending bit is still latched.
EIC_IntAck  input  1  toggle acknowledge from the core domain; asynchronous to this block.
EIC_IntReq  output  1  interrupt request level to the core.
EIC_IntId  output  ID_WIDTH  ID of the interrupt being requested.
EIC_Pending  output  NUM_SRC  pending-bit status, for debug and software visibility.

Behaviour:
- Reset (Sys_Reset low, asynchronous):
  - EIC_IntReq=0, EIC_IntId=0, EIC_Pending=0.
  - State=IDLE, counter=0, Src_Last=0, Ack_Sync_Last=0.
  - The ack synchronizer is reset to 0. The core side shares Sys_Reset, so the toggle phase starts aligned on both sides.
- Edge detection: pending[i] is set on the clock edge after cycle N when Src_IntReq[i]=1 and Src_Last[i]=0 in cycle N. Level-high sources do not re-trigger.
- Arbitration: eligible = pending & ~Src_IntMask. Fixed priority selects the lowest eligible index.
- Ack detection: EIC_IntAck passes through a two-flop Synchronizer to give Ack_Sync. ack_evt = Ack_Sync ^ Ack_Sync_Last; Ack_Sync_Last updates every cycle.
- FSM states: IDLE, SETUP, REQ, RECOVER.
  - IDLE: if eligible != 0 -> EIC_IntId <= selected index, counter <= SETUP_CYCLES-1, go to SETUP.
  - SETUP: EIC_IntId is frozen. When counter=0 -> EIC_IntReq <= 1 and go to REQ; otherwise decrement the counter. Latency: EIC_IntReq rises SETUP_CYCLES cycles after EIC_IntId changes.
  - REQ: hold EIC_IntReq=1 and EIC_IntId until ack_evt. On ack_evt -> EIC_IntReq <= 0, pending[EIC_IntId] <= 0, counter <= LOW_CYCLES-1, go to RECOVER.
  - RECOVER: EIC_IntReq=0. When counter=0 -> go to IDLE; otherwise decrement. Back-to-back request period is therefore >= LOW_CYCLES low cycles.
- Boundary conditions:
  - Mask changes or higher-priority arrivals during SETUP, REQ or RECOVER do not alter the committed ID. They are considered in the next IDLE.
  - A new rising edge on a source in the same cycle its pending bit is cleared by an ack: set wins, and the event is kept pending.
  - Repeat edges on an already-pending source merge into one pending bit; there is no event count.
  - ack_evt outside REQ is ignored; it is still absorbed into Ack_Sync_Last.
  - All sources masked with pending bits set: stay in IDLE, EIC_IntReq=0, EIC_Pending still shows the bits.
  - Reset mid-handshake aborts immediately: EIC_IntReq=0 and all pending events are lost.
- EIC_IntReq and EIC_IntId are driven directly from flops, with no combinational path from any input.

Decomposition:
- Shared defines file holds the state encodings (IDLE/SETUP/REQ/RECOVER) and uses the existing TRUE/FALSE defines.
- Reuse the existing Synchronizer module for EIC_IntAck.
- One new sub-module, eic_priority_encoder: combinational; NUM_SRC-bit eligible vector in, ID_WIDTH index and valid flag out.

Test Plan:
- Single event: pulse Src_IntReq[1] with no mask -> EIC_IntId=1, EIC_IntReq rises 2 cycles later. Toggle EIC_IntAck -> EIC_IntReq falls 3 cycles after the toggle (2 synchronizer cycles + 1), pending[1] clears, and EIC_IntReq stays low >= 3 cycles.
- Priority: raise sources 0 and 1 in the same cycle -> ID 0 is served first. After its ack and recovery, ID 1 is served; EIC_Pending goes 11 -> 10 -> 00.
- Masking: Src_IntMask=01 with pending=11 -> ID 1 served, pending[0] stays 1. Clear the mask -> ID 0 served next.
- Set/clear collision: new edge on source 0 in the same cycle its ack clears it -> pending[0] stays 1 and a second request for ID 0 follows the recovery.
- Spurious ack: toggle EIC_IntAck while in IDLE -> no state change. A later genuine request still needs a fresh toggle to complete.
- Reset mid-REQ: assert Sys_Reset low -> EIC_IntReq=0, EIC_Pending=0, state IDLE, asynchronously without waiting for a clock edge.
